// File: rtl/mac_fifo_pkg.sv
// Shared types and helpers for the MAC TX store-and-forward packet FIFO.
package mac_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDrop
  } wr_state_e;

  localparam int unsigned MAC_KEEP_BITS = 8;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mac_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with 1-cycle latency.
// Only the read register is reset; the array itself is never cleared.
module mac_fifo_ram #(
  parameter int unsigned WIDTH = 73,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the output stage and holds while rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mac_tx_pkt_fifo.sv
// Store-and-forward packet FIFO feeding the 10GbE MAC TX AXI-Stream port; whole-frame tail drop.
// Define MAC_TX_FIFO_STATS_EN to add the saturating tx/drop frame counters and stats_clear.
module mac_tx_pkt_fifo
  import mac_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH = 512,
`ifdef MAC_TX_FIFO_STATS_EN
  parameter int unsigned STATS_WIDTH = 32,
`endif
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic                   clk156,
  input  logic                   areset_clk156,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
`ifdef MAC_TX_FIFO_STATS_EN
  input  logic                   stats_clear,
  output logic [STATS_WIDTH-1:0] stat_tx_frames,
  output logic [STATS_WIDTH-1:0] stat_drop_frames,
`endif
  output logic                   drop_pulse,
  output logic [PTR_W-1:0]       fill_level
);

  localparam int unsigned ADDR_W = PTR_W - 1;
  localparam int unsigned WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;

  wr_state_e         state_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_commit_q, rd_ptr_q, frames_ready_q, occupancy;
  logic              ready_q, out_valid_q;
  logic              accept, full, wr_en, commit, rd_en, tx_last;
  logic [WORD_W-1:0] rd_word;

  // Occupancy uses this cycle's registers, so a same-cycle read never frees the slot early.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign accept    = s_axis_tvalid & ready_q;
  assign wr_en     = accept & ~full & (state_q != StDrop);
  assign commit    = wr_en & s_axis_tlast;
  assign tx_last   = out_valid_q & m_axis_tready & m_axis_tlast;
  // Only committed beats are read, so the MAC never sees a partial frame.
  assign rd_en     = (~out_valid_q | m_axis_tready) & (frames_ready_q != '0)
                   & (rd_ptr_q != wr_commit_q);

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      ready_q     <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      drop_pulse <= 1'b0;
      if (accept) begin
        case (state_q)
          StIdle, StWrite: begin
            if (full) begin
              wr_ptr_q <= wr_commit_q;
              if (s_axis_tlast) begin
                drop_pulse <= 1'b1;
                state_q    <= StIdle;
              end else begin
                state_q <= StDrop;
              end
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (s_axis_tlast) begin
                wr_commit_q <= wr_ptr_q + 1'b1;
                state_q     <= StIdle;
              end else begin
                state_q <= StWrite;
              end
            end
          end
          StDrop: begin
            if (s_axis_tlast) begin
              drop_pulse <= 1'b1;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      rd_ptr_q       <= '0;
      frames_ready_q <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rd_en) begin
        out_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      if (commit && !tx_last) begin
        frames_ready_q <= frames_ready_q + 1'b1;
      end else if (!commit && tx_last) begin
        frames_ready_q <= frames_ready_q - 1'b1;
      end
    end
  end

  mac_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk156),
    .rst     (areset_clk156),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_word;
  assign m_axis_tvalid = out_valid_q;
  assign s_axis_tready = ready_q;
  assign fill_level    = occupancy;

`ifdef MAC_TX_FIFO_STATS_EN
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else if (stats_clear) begin
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else begin
      if (tx_last && (stat_tx_frames != '1)) stat_tx_frames <= stat_tx_frames + 1'b1;
      if (drop_pulse && (stat_drop_frames != '1)) stat_drop_frames <= stat_drop_frames + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_tx_pkt_fifo.sv
// Randomised bench for mac_tx_pkt_fifo: frames are scoreboarded against an ideal frame queue.
// Statistics checks are compiled when MAC_TX_FIFO_STATS_EN is defined.
module tb_mac_tx_pkt_fifo;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk156 = 1'b0;
  logic          areset_clk156 = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          drop_pulse;
  logic [PW-1:0] fill_level;
`ifdef MAC_TX_FIFO_STATS_EN
  logic          stats_clear = 1'b0;
  logic [31:0]   stat_tx_frames, stat_drop_frames;
`endif

  always #5 clk156 = ~clk156;

  mac_tx_pkt_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk156           (clk156),
    .areset_clk156    (areset_clk156),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
`ifdef MAC_TX_FIFO_STATS_EN
    .stats_clear      (stats_clear),
    .stat_tx_frames   (stat_tx_frames),
    .stat_drop_frames (stat_drop_frames),
`endif
    .drop_pulse       (drop_pulse),
    .fill_level       (fill_level)
  );

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  beat_t exp_q[$], rx_q[$];
  // Sink mode: 0 stall, 1 always ready, 2 random ready, 3 accept one tlast beat with stats_clear.
  int    mode = 1;
  int    gap_cnt = 0, drop_cnt = 0, drop_cyc = -1, rise_cyc = -1, last_cyc = -1;
  int    fill_max = 0, fr_max = 0;
  bit    in_frame = 0, prev_valid = 0;

  always @(posedge clk156) cyc <= cyc + 1;

  // Sink: drives m_axis_tready and records every handshaken beat.
  always @(negedge clk156) begin
    beat_t b;
    if (areset_clk156) begin
      in_frame      = 0;
      prev_valid    = 0;
      m_axis_tready = 1'b0;
`ifdef MAC_TX_FIFO_STATS_EN
      stats_clear   = 1'b0;
`endif
    end else begin
      case (mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        2:       m_axis_tready = ($urandom_range(3) != 0);
        default: m_axis_tready = m_axis_tvalid && m_axis_tlast;
      endcase
`ifdef MAC_TX_FIFO_STATS_EN
      stats_clear = (mode == 3) && m_axis_tvalid && m_axis_tlast;
`endif
      if (mode == 3 && m_axis_tvalid && m_axis_tlast) mode = 0;
      if (m_axis_tvalid && !prev_valid) rise_cyc = cyc;
      prev_valid = m_axis_tvalid;
      if (in_frame && !m_axis_tvalid) gap_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata;
        b.keep = m_axis_tkeep;
        b.last = m_axis_tlast;
        rx_q.push_back(b);
        in_frame = !m_axis_tlast;
      end
      if (drop_pulse) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
      if (int'(fill_level) > fill_max) fill_max = int'(fill_level);
      if (int'(dut.frames_ready_q) > fr_max) fr_max = int'(dut.frames_ready_q);
    end
  end

  task automatic send_frame(input int len, input logic [KW-1:0] last_keep, input bit kept);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      @(negedge clk156);
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.keep = b.last ? last_keep : '1;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tvalid = 1'b1;
      if (b.last) last_cyc = cyc;
      if (kept) exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk156);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk156);
    repeat (2) @(negedge clk156);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk156);
    n_chk++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, drop_pulse,
         fill_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%h keep=%h drop=%b fill=%0d want all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
               drop_pulse, fill_level);
    end
`ifdef MAC_TX_FIFO_STATS_EN
    n_chk++;
    if (stat_tx_frames !== 0 || stat_drop_frames !== 0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_tx_frames, stat_drop_frames);
    end
`endif
    areset_clk156 = 1'b0;
    repeat (2) @(negedge clk156);
    n_chk++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got tready=%b tvalid=%b want 1/0", s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic test_single_frame();
    exp_q.delete(); rx_q.delete(); rise_cyc = -1; mode = 1;
    send_frame(8, 8'h0F, 1);
    idle(1);
    wait_rx(8, 50);
    n_chk++;
    if (rise_cyc - last_cyc != 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 2", rise_cyc - last_cyc);
    end
    n_chk++;
    if (rx_q.size() != 8) begin
      n_fail++;
      $display("FAIL single_count: got %0d want 8", rx_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (gap_cnt != 0 || fill_level !== '0) begin
      n_fail++;
      $display("FAIL single_gap_fill: got gaps=%0d fill=%0d want 0/0", gap_cnt, fill_level);
    end
`ifdef MAC_TX_FIFO_STATS_EN
    n_chk++;
    if (stat_tx_frames !== 1) begin
      n_fail++;
      $display("FAIL single_stat_tx: got %0d want 1", stat_tx_frames);
    end
`endif
  endtask

  task automatic test_oversize();
    exp_q.delete(); rx_q.delete(); drop_cnt = 0; fill_max = 0; mode = 1;
    send_frame(DEPTH + 1, '1, 0);
    idle(1);
    repeat (6) @(negedge clk156);
    n_chk++;
    if (drop_cnt != 1 || drop_cyc != last_cyc + 1) begin
      n_fail++;
      $display("FAIL oversize_drop: got pulses=%0d at +%0d want 1 at +1", drop_cnt,
               drop_cyc - last_cyc);
    end
    n_chk++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL oversize_output: got %0d beats want 0", rx_q.size());
    end
    n_chk++;
    if (fill_max != DEPTH || fill_level !== '0) begin
      n_fail++;
      $display("FAIL oversize_fill: got peak=%0d end=%0d want %0d/0", fill_max, fill_level, DEPTH);
    end
`ifdef MAC_TX_FIFO_STATS_EN
    n_chk++;
    if (stat_drop_frames !== 1 || stat_tx_frames !== 1) begin
      n_fail++;
      $display("FAIL oversize_stats: got drop=%0d tx=%0d want 1/1", stat_drop_frames,
               stat_tx_frames);
    end
`endif
  endtask

  task automatic test_hold_drop();
    int  len1 = DEPTH - 6;
    int  len2 = 8;
    bit  dropped;
    exp_q.delete(); rx_q.delete(); drop_cnt = 0; mode = 0;
    send_frame(len1, '1, 1);
    idle(4);
    // One beat of the stalled frame sits in the output register, outside the buffer.
    dropped = (len1 - 1 + len2) > DEPTH;
    send_frame(len2, KW'($urandom_range(255, 1)), !dropped);
    idle(3);
    n_chk++;
    if (drop_cnt != (dropped ? 1 : 0)) begin
      n_fail++;
      $display("FAIL hold_drop_pulse: got %0d want %0d", drop_cnt, dropped ? 1 : 0);
    end
    mode = 1;
    wait_rx(exp_q.size(), 200);
    n_chk++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL hold_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL hold_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (fill_level !== '0) begin
      n_fail++;
      $display("FAIL hold_fill: got %0d want 0", fill_level);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    exp_q.delete(); rx_q.delete(); drop_cnt = 0; gap_cnt = 0; fr_max = 0; mode = 2;
    for (int f = 0; f < 64; f++) begin
      // Throttle only when the un-drained beat count could overflow the buffer.
      for (int g = 0; g < 1000 && (sent - rx_q.size() + 3) > int'(DEPTH); g++) idle(1);
      send_frame(3, KW'($urandom_range(255, 1)), 1);
      sent += 3;
    end
    idle(1);
    wait_rx(sent, 2000);
    n_chk++;
    if (rx_q.size() != sent) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), sent);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (gap_cnt != 0 || drop_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_gap_drop: got gaps=%0d drops=%0d want 0/0", gap_cnt, drop_cnt);
    end
    n_chk++;
    if (fr_max >= int'(DEPTH) || dut.frames_ready_q !== '0 || fill_level !== '0) begin
      n_fail++;
      $display("FAIL b2b_frames_ready: got max=%0d end=%0d fill=%0d want <%0d/0/0", fr_max,
               dut.frames_ready_q, fill_level, DEPTH);
    end
    mode = 1;
  endtask

  task automatic test_reset_mid_output();
    bit saw_last = 0;
    exp_q.delete(); rx_q.delete(); mode = 1;
    send_frame(20, '1, 1);
    idle(1);
    wait_rx(5, 100);
    areset_clk156 = 1'b1;
    #1;
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, drop_pulse, fill_level,
         s_axis_tready} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got vld=%b last=%b data=%h keep=%h fill=%0d rdy=%b want 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, fill_level,
               s_axis_tready);
    end
    foreach (rx_q[i]) if (rx_q[i].last) saw_last = 1;
    n_chk++;
    if (saw_last || rx_q.size() >= 20) begin
      n_fail++;
      $display("FAIL midreset_truncate: got beats=%0d tlast=%b want <20/0", rx_q.size(), saw_last);
    end
    repeat (2) @(negedge clk156);
    areset_clk156 = 1'b0;
    repeat (2) @(negedge clk156);
    exp_q.delete(); rx_q.delete();
    send_frame(4, 8'h3F, 1);
    idle(1);
    wait_rx(4, 50);
    n_chk++;
    if (rx_q.size() != 4) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d want 4", rx_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
`ifdef MAC_TX_FIFO_STATS_EN
    n_chk++;
    if (stat_tx_frames !== 1 || stat_drop_frames !== 0) begin
      n_fail++;
      $display("FAIL midreset_stats: got tx=%0d drop=%0d want 1/0", stat_tx_frames,
               stat_drop_frames);
    end
`endif
  endtask

`ifdef MAC_TX_FIFO_STATS_EN
  task automatic test_stats_clear();
    exp_q.delete(); rx_q.delete(); mode = 0;
    send_frame(1, 8'h01, 1);
    idle(1);
    repeat (5) @(negedge clk156);
    mode = 3;
    repeat (3) @(negedge clk156);
    n_chk++;
    if (rx_q.size() != 1 || stat_tx_frames !== 0) begin
      n_fail++;
      $display("FAIL stats_clear: got beats=%0d tx=%0d want 1/0", rx_q.size(), stat_tx_frames);
    end
    mode = 1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_oversize();
    test_hold_drop();
    test_back_to_back();
    test_reset_mid_output();
`ifdef MAC_TX_FIFO_STATS_EN
    test_stats_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
